// File: rtl/calc_pkg.sv
// Shared types and constants for the calc issue/collect block.
package calc_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int PIPE_LATENCY = 3;

    typedef logic signed [DATA_WIDTH-1:0] calc_word_t;

    typedef struct packed {
        calc_word_t a;
        calc_word_t b;
        calc_word_t c;
        calc_word_t d;
    } calc_operands_t;

endpackage

// File: rtl/calc_issue_collect_if.sv
// Bundle of stream, pipeline and status signals around calc_issue_collect.
interface calc_issue_collect_if
    import calc_pkg::*;
#(
    parameter int RES_DEPTH = 4
) ();
    localparam int IW = $clog2(RES_DEPTH + 1);

    logic       s_valid;
    logic       s_ready;
    calc_word_t s_a;
    calc_word_t s_b;
    calc_word_t s_c;
    calc_word_t s_d;

    calc_word_t a;
    calc_word_t b;
    calc_word_t c;
    calc_word_t d;
    logic       a_valid;
    logic       b_valid;
    logic       c_valid;
    logic       d_valid;
    calc_word_t q;
    logic       q_valid;

    logic       m_valid;
    logic       m_ready;
    calc_word_t m_q;

    logic [IW-1:0] inflight;
    logic          err;

    modport slave (
        input  s_valid, s_a, s_b, s_c, s_d, q, q_valid, m_ready,
        output s_ready, a, b, c, d, a_valid, b_valid, c_valid, d_valid,
               m_valid, m_q, inflight, err
    );

    modport master (
        output s_valid, s_a, s_b, s_c, s_d, q, q_valid, m_ready,
        input  s_ready, a, b, c, d, a_valid, b_valid, c_valid, d_valid,
               m_valid, m_q, inflight, err
    );

endinterface

// File: rtl/calc_issue_collect_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: empty/full come from the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

    assign count = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (count == (AW+1)'(DEPTH));
    assign dout  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/calc_issue_collect.sv
// Buffers operand tuples, issues them to the q pipeline under result-FIFO credit,
// and collects q results into a result FIFO drained by a valid/ready port.
module calc_issue_collect
    import calc_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4
) (
    input  logic clk_i,
    input  logic artsn_i,
    calc_issue_collect_if.slave bus
);
    localparam int IW = $clog2(RES_DEPTH + 1);
    localparam int CW = $clog2(CMD_DEPTH) + 1;
    localparam int RW = $clog2(RES_DEPTH) + 1;

    calc_operands_t cmd_din;
    calc_operands_t cmd_dout;
    calc_operands_t ops_q;
    logic           cmd_full;
    logic           cmd_empty;
    logic           cmd_push;
    logic [CW-1:0]  unused_cmd_count;

    calc_word_t     res_dout;
    logic           res_full;
    logic           res_empty;
    logic           res_push;
    logic           res_pop;
    logic [RW-1:0]  res_count;

    logic [IW-1:0]  inflight;
    logic [IW:0]    credit_used;
    logic           issue;
    logic           ret;
    logic           ready_en;
    logic           valid_q;
    logic           err_q;

    assign cmd_din  = {bus.s_a, bus.s_b, bus.s_c, bus.s_d};
    assign cmd_push = bus.s_valid && bus.s_ready;

    sync_fifo #(
        .WIDTH ($bits(calc_operands_t)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk_i),
        .rst_n (artsn_i),
        .push  (cmd_push),
        .pop   (issue),
        .din   (cmd_din),
        .dout  (cmd_dout),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (unused_cmd_count)
    );

    // Every issued tuple owns a result slot until it is popped, so q never overflows.
    assign credit_used = (IW+1)'(res_count) + (IW+1)'(inflight);
    assign issue       = !cmd_empty && (credit_used < (IW+1)'(RES_DEPTH));
    assign ret         = bus.q_valid && (inflight != '0);
    assign res_push    = ret && !res_full;
    assign res_pop     = bus.m_ready && !res_empty;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk   (clk_i),
        .rst_n (artsn_i),
        .push  (res_push),
        .pop   (res_pop),
        .din   (bus.q),
        .dout  (res_dout),
        .full  (res_full),
        .empty (res_empty),
        .count (res_count)
    );

    always_ff @(posedge clk_i or negedge artsn_i) begin
        if (!artsn_i) begin
            ready_en <= 1'b0;
            ops_q    <= '0;
            valid_q  <= 1'b0;
            inflight <= '0;
            err_q    <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            valid_q  <= issue;
            if (issue) ops_q <= cmd_dout;
            if (issue && !ret)      inflight <= inflight + IW'(1);
            else if (!issue && ret) inflight <= inflight - IW'(1);
            if (bus.q_valid && ((inflight == '0) || res_full)) err_q <= 1'b1;
        end
    end

    assign bus.s_ready  = ready_en && !cmd_full;
    assign bus.a        = ops_q.a;
    assign bus.b        = ops_q.b;
    assign bus.c        = ops_q.c;
    assign bus.d        = ops_q.d;
    assign bus.a_valid  = valid_q;
    assign bus.b_valid  = valid_q;
    assign bus.c_valid  = valid_q;
    assign bus.d_valid  = valid_q;
    assign bus.m_valid  = !res_empty;
    assign bus.m_q      = res_dout;
    assign bus.inflight = inflight;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_calc_issue_collect.sv
// Self-checking bench for calc_issue_collect with a behavioural q pipeline attached.
module tb_calc_issue_collect;
    import calc_pkg::*;

    logic clk;
    logic rst_n;
    logic force_qv;
    int   force_val;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_q[$];
    int   got_q[$];
    int   n_issue  = 0;
    int   n_over   = 0;
    int   res_model = 0;

    calc_issue_collect_if #(.RES_DEPTH(4)) bus ();

    calc_issue_collect #(
        .CMD_DEPTH (4),
        .RES_DEPTH (4)
    ) dut (
        .clk_i   (clk),
        .artsn_i (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int ref_q(input int a, input int b, input int c, input int d);
        int t;
        t = (a - b) * (3 * c + 1) - 4 * d;
        return t >>> 1;
    endfunction

    // Stand-in for the compute pipeline: PIPE_LATENCY register stages, shares the reset.
    logic [PIPE_LATENCY-1:0] pv;
    int                      pq [PIPE_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            for (int i = 0; i < PIPE_LATENCY; i++) pq[i] <= 0;
        end else begin
            pv    <= {pv[PIPE_LATENCY-2:0], bus.a_valid & bus.b_valid & bus.c_valid & bus.d_valid};
            pq[0] <= ((int'(bus.a) - int'(bus.b)) * (int'(bus.c) * 3 + 1) - (int'(bus.d) <<< 2)) >>> 1;
            for (int i = 1; i < PIPE_LATENCY; i++) pq[i] <= pq[i-1];
        end
    end

    assign bus.q_valid = pv[PIPE_LATENCY-1] | force_qv;
    assign bus.q       = force_qv ? force_val : pq[PIPE_LATENCY-1];

    // Monitor: sampled mid-cycle, so a seen handshake completes at the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            got_q.delete();
            res_model = 0;
        end else begin
            if (bus.s_valid && bus.s_ready)
                exp_q.push_back(ref_q(bus.s_a, bus.s_b, bus.s_c, bus.s_d));
            if (bus.m_valid && bus.m_ready)
                got_q.push_back(int'(bus.m_q));
            if (bus.a_valid) n_issue++;
            if (int'(bus.inflight) + res_model > 4) n_over++;
            if (bus.q_valid && !force_qv) res_model++;
            if (bus.m_valid && bus.m_ready) res_model--;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int a, input int b, input int c, input int d);
        int k;
        bus.s_valid = 1'b1;
        bus.s_a = a;
        bus.s_b = b;
        bus.s_c = c;
        bus.s_d = d;
        k = 0;
        while (!bus.s_ready && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) chk("send_timeout", 64'(k), 64'(0));
        tick();
    endtask

    task automatic wait_got(input int n, input string tag);
        int k;
        k = 0;
        while (got_q.size() < n && k < 300) begin
            tick();
            k++;
        end
        chk(tag, 64'(got_q.size() >= n), 64'(1));
    endtask

    task automatic drain_check(input string tag);
        chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk(tag, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_issue;
        int base_over;
        int k;

        rst_n = 1'b1;
        force_qv = 1'b0;
        force_val = 0;
        bus.s_valid = 1'b0;
        bus.s_a = '0;
        bus.s_b = '0;
        bus.s_c = '0;
        bus.s_d = '0;
        bus.m_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;

        chk("rst_s_ready", bus.s_ready, 1'b0);
        chk("rst_m_valid", bus.m_valid, 1'b0);
        chk("rst_a_valid", bus.a_valid, 1'b0);
        chk("rst_a", bus.a, 32'd0);
        chk("rst_inflight", bus.inflight, 0);
        chk("rst_err", bus.err, 1'b0);

        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_ready_before_edge", bus.s_ready, 1'b0);
        tick();
        chk("rst_ready_after", bus.s_ready, 1'b1);

        // 1: single tuple, 5-cycle latency, one-cycle m_valid pulse
        bus.m_ready = 1'b1;
        send(10, 4, 2, 3);
        bus.s_valid = 1'b0;
        repeat (4) tick();
        chk("t1_early", bus.m_valid, 1'b0);
        tick();
        chk("t1_valid", bus.m_valid, 1'b1);
        chk("t1_q", 64'(int'(bus.m_q)), 64'(15));
        tick();
        chk("t1_pulse", bus.m_valid, 1'b0);
        drain_check("t1_sb");

        // 2: negative result
        send(1, 5, 0, 1);
        bus.s_valid = 1'b0;
        k = 0;
        while (!bus.m_valid && k < 20) begin
            tick();
            k++;
        end
        chk("t2_q", 64'(int'(bus.m_q)), 64'(-4));
        tick();
        drain_check("t2_sb");

        // 3: stall with m_ready low, credit limits issue to 4
        bus.m_ready = 1'b0;
        base_issue = n_issue;
        base_over  = n_over;
        for (int i = 0; i < 8; i++)
            send(int'($urandom), int'($urandom), int'($urandom), int'($urandom));
        bus.s_valid = 1'b0;
        chk("t3_ready_low", bus.s_ready, 1'b0);
        chk("t3_accepts", 64'(exp_q.size()), 64'(8));
        repeat (10) tick();
        chk("t3_issues", 64'(n_issue - base_issue), 64'(4));
        chk("t3_credit", 64'(n_over - base_over), 64'(0));
        chk("t3_inflight", bus.inflight, 0);
        chk("t3_m_valid", bus.m_valid, 1'b1);
        bus.m_ready = 1'b1;
        wait_got(8, "t3_timeout");
        tick();
        drain_check("t3_sb");
        chk("t3_err", bus.err, 1'b0);

        // 4: streaming with random operands
        for (int i = 0; i < 16; i++)
            send(int'($urandom), int'($urandom), int'($urandom_range(2000, 0)) - 1000, int'($urandom));
        bus.s_valid = 1'b0;
        wait_got(16, "t4_timeout");
        tick();
        drain_check("t4_sb");
        chk("t4_err", bus.err, 1'b0);
        chk("t4_credit", 64'(n_over - base_over), 64'(0));

        // 5: spurious q_valid with nothing in flight
        chk("t5_idle", bus.inflight, 0);
        force_val = int'($urandom);
        force_qv = 1'b1;
        tick();
        force_qv = 1'b0;
        chk("t5_err", bus.err, 1'b1);
        chk("t5_m_valid", bus.m_valid, 1'b0);
        chk("t5_inflight", bus.inflight, 0);
        repeat (5) tick();
        chk("t5_sticky", bus.err, 1'b1);
        chk("t5_no_result", 64'(got_q.size()), 64'(0));

        // 6: reset with 2 in flight and 1 buffered
        bus.m_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(int'($urandom), int'($urandom), int'($urandom), int'($urandom));
        bus.s_valid = 1'b0;
        chk("t6_issuing", bus.a_valid, 1'b1);
        chk("t6_inflight_pre", bus.inflight, 2);
        rst_n = 1'b0;
        #1;
        chk("t6_a_valid", bus.a_valid, 1'b0);
        chk("t6_d_valid", bus.d_valid, 1'b0);
        chk("t6_m_valid", bus.m_valid, 1'b0);
        chk("t6_inflight", bus.inflight, 0);
        chk("t6_err_clr", bus.err, 1'b0);
        chk("t6_s_ready", bus.s_ready, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (8) tick();
        chk("t6_no_stale", bus.m_valid, 1'b0);
        bus.m_ready = 1'b1;
        send(100, -20, 5, -7);
        bus.s_valid = 1'b0;
        wait_got(1, "t6_timeout");
        chk("t6_q", 64'(got_q[0]), 64'(974));
        tick();
        drain_check("t6_sb");
        chk("t6_err", bus.err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
